gs_sequencer: RTL and testbench

Frame-level controller for the grayscale stage. On a `start` pulse it streams N*M RGB pixels (3 bytes each, R,G,B order) out of the source frame memory into the grayscaler, captures each 8-bit grayscale result and writes it to the destination memory at the pixel index. It also reports completion or error to the top-level controller. It sits between the top-level controller, the source and destination frame memories, and the grayscaler.

---
 rtl/gs_pkg.sv | 18 +
 rtl/gs_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_gs_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gs_pkg.sv
// gs_pkg: shared types and constants for the grayscale-stage frame sequencer.
//   gs_state_e          - sequencer states
//   GS_BYTES_PER_PIXEL  - source bytes per pixel (R,G,B)
//   GS_TIMEOUT          - default watchdog limit in cycles
package gs_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } gs_state_e;

  localparam int unsigned GS_BYTES_PER_PIXEL = 3;
  localparam int unsigned GS_TIMEOUT         = 64;

endpackage

// File: rtl/gs_sequencer.sv
// gs_sequencer: frame-level controller for the grayscale stage.
// On start it streams 3*N*M source bytes into the grayscaler, writes each
// returned grayscale byte to the destination memory at its pixel index and
// reports done / err to the top-level controller.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, abort            frame request (IDLE only) / forced return to IDLE
//   busy, done, err         status: RUN|DRAIN, one-cycle completion, sticky error
//   src_rd_en, src_addr     source byte read (data reaches the grayscaler next cycle)
//   gs_enable               grayscaler enable
//   gs_pause                grayscaler stall request (blocks reads)
//   gs_valid, gs_data       one grayscale result per pixel
//   gs_done                 grayscaler end-of-frame status
//   dst_wr_en, dst_addr,
//   dst_data                registered destination write (one cycle after gs_valid)
module gs_sequencer
  import gs_pkg::*;
#(
  parameter int unsigned N       = 2,
  parameter int unsigned M       = 2,
  parameter int unsigned AW      = 8,
  parameter int unsigned TIMEOUT = GS_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          src_rd_en,
  output logic [AW-1:0] src_addr,
  output logic          gs_enable,
  input  logic          gs_pause,
  input  logic          gs_valid,
  input  logic [7:0]    gs_data,
  input  logic          gs_done,
  output logic          dst_wr_en,
  output logic [AW-1:0] dst_addr,
  output logic [7:0]    dst_data
);

  localparam int unsigned NPIX   = N * M;
  localparam int unsigned NBYTES = GS_BYTES_PER_PIXEL * NPIX;
  localparam int unsigned WDW    = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0]  LAST_RD  = AW'(NBYTES - 1);
  localparam logic [AW-1:0]  NPIX_A   = AW'(NPIX);
  localparam logic [AW-1:0]  NPIX_M1  = AW'(NPIX - 1);
  localparam logic [WDW-1:0] WDOG_MAX = WDW'(TIMEOUT);
  localparam logic [WDW-1:0] WDOG_ONE = WDW'(1);

  gs_state_e      state_q, state_d;
  logic [AW-1:0]  rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           err_q, err_d;
  logic           seen_q, seen_d;     // gs_done observed during this frame
  logic           dst_wr_en_q, dst_wr_en_d;
  logic [AW-1:0]  dst_addr_q, dst_addr_d;
  logic [7:0]     dst_data_q, dst_data_d;

  logic           seen_now;
  logic           drain_end;
  logic           fault;

  always_comb begin
    // NOTE: every signal written in this block is given a default first, so no
    // path can leave one unassigned and infer a latch.
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    wdog_d      = wdog_q;
    err_d       = err_q;
    seen_d      = seen_q;
    dst_wr_en_d = 1'b0;
    dst_addr_d  = dst_addr_q;
    dst_data_d  = dst_data_q;
    busy        = 1'b0;
    gs_enable   = 1'b0;
    done        = 1'b0;
    seen_now    = seen_q || gs_done;
    drain_end   = (state_q == S_DRAIN) && (wr_cnt_q == NPIX_A);
    fault       = 1'b0;

    case (state_q)
      S_RUN, S_DRAIN: begin
        busy      = 1'b1;
        gs_enable = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase

    // RUN is left on the final read, so being in RUN means a read is still owed.
    src_rd_en = (state_q == S_RUN) && !gs_pause && !abort;

    if (abort) begin
      state_d  = S_IDLE;
      rd_cnt_d = '0;
      wr_cnt_d = '0;
      wdog_d   = '0;
      seen_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_RUN;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
            wdog_d   = WDOG_ONE;
            err_d    = 1'b0;
            seen_d   = 1'b0;
          end
        end

        S_RUN, S_DRAIN: begin
          // Watchdog holds the number of cycles elapsed since the last
          // gs_valid (or the start pulse); ERROR is entered when it hits TIMEOUT.
          wdog_d = gs_valid ? WDOG_ONE : wdog_q + 1'b1;
          if (gs_done) seen_d = 1'b1;

          fault = (!gs_valid && (wdog_d == WDOG_MAX))
               || (gs_valid && (wr_cnt_q == NPIX_A))
               || (gs_done && (wr_cnt_q < NPIX_M1))
               || (drain_end && !seen_now);

          if (fault) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            if (gs_valid) begin
              dst_wr_en_d = 1'b1;
              dst_addr_d  = wr_cnt_q;
              dst_data_d  = gs_data;
              wr_cnt_d    = wr_cnt_q + 1'b1;
            end
            // The last address is never incremented past, so rd_cnt cannot wrap.
            if (src_rd_en) begin
              if (rd_cnt_q == LAST_RD) state_d  = S_DRAIN;
              else                     rd_cnt_d = rd_cnt_q + 1'b1;
            end
            if (drain_end) state_d = S_DONE;
          end
        end

        S_DONE, S_ERROR: state_d = S_IDLE;
        default:         state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      wdog_q      <= '0;
      err_q       <= 1'b0;
      seen_q      <= 1'b0;
      dst_wr_en_q <= 1'b0;
      dst_addr_q  <= '0;
      dst_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // independent of statement order.
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      wdog_q      <= wdog_d;
      err_q       <= err_d;
      seen_q      <= seen_d;
      dst_wr_en_q <= dst_wr_en_d;
      dst_addr_q  <= dst_addr_d;
      dst_data_q  <= dst_data_d;
    end
  end

  assign err       = err_q;
  assign src_addr  = rd_cnt_q;
  assign dst_wr_en = dst_wr_en_q;
  assign dst_addr  = dst_addr_q;
  assign dst_data  = dst_data_q;

endmodule

// File: tb/tb_gs_sequencer.sv
// tb_gs_sequencer: self-checking bench for gs_sequencer (N=M=2, AW=8, TIMEOUT=64).
// A grayscaler model answers every third byte read with 8'h10+k two cycles
// later; a frame-level model (read count, pending write, frame end cycle)
// is compared with the DUT outputs on every negative clock edge.
module tb_gs_sequencer;

  localparam int N    = 2;
  localparam int M    = 2;
  localparam int AW   = 8;
  localparam int TO   = 64;
  localparam int NPIX = N * M;

  localparam int K_NORMAL  = 0;
  localparam int K_TIMEOUT = 1;
  localparam int K_ABORT   = 2;
  localparam int K_EARLY   = 3;
  localparam int K_RESET   = 4;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    bit         last;
  } gv_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort;
  logic          busy, done, err;
  logic          src_rd_en;
  logic [AW-1:0] src_addr;
  logic          gs_enable, gs_pause, gs_valid, gs_done;
  logic [7:0]    gs_data;
  logic          dst_wr_en;
  logic [AW-1:0] dst_addr;
  logic [7:0]    dst_data;

  int n_checks = 0;
  int n_fail   = 0;

  // frame model state
  bit         chk_on = 1'b0;
  int         cyc = 0;
  int         end_cyc;
  int         frame_kind;
  int         reads_mdl, wr_idx, dut_reads, done_cnt;
  int         first_rd_cyc, done_cyc, err_rise;
  bit         pend_wr, nxt_wr;
  logic [7:0] pend_data, nxt_data;
  logic [7:0] mem [NPIX];

  gs_sequencer #(.N(N), .M(M), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .src_rd_en(src_rd_en), .src_addr(src_addr), .gs_enable(gs_enable),
    .gs_pause(gs_pause), .gs_valid(gs_valid), .gs_data(gs_data), .gs_done(gs_done),
    .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_data(dst_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the frame model.
  always @(negedge clk) begin : cmp
    bit eb, erd, err_kind;
    if (chk_on && cyc >= 1) begin
      eb       = cyc < end_cyc;
      erd      = eb && (reads_mdl < 3 * NPIX) && !gs_pause && !abort;
      err_kind = (frame_kind == K_TIMEOUT) || (frame_kind == K_EARLY);
      check("busy", busy, eb);
      check("gs_enable", gs_enable, eb);
      check("src_rd_en", src_rd_en, erd);
      if (erd) begin
        check("src_addr", src_addr, reads_mdl);
        reads_mdl++;
      end
      if (eb && gs_pause && reads_mdl < 3 * NPIX)
        check("src_addr_hold", src_addr, reads_mdl);
      check("dst_wr_en", dst_wr_en, pend_wr);
      if (pend_wr && dst_wr_en) begin
        check("dst_addr", dst_addr, wr_idx);
        check("dst_data", dst_data, pend_data);
        if (wr_idx < NPIX) mem[wr_idx] = dst_data;
        wr_idx++;
      end
      check("done", done, (!err_kind && frame_kind != K_ABORT && cyc == end_cyc));
      check("err", err, (err_kind && cyc >= end_cyc));
      if (src_rd_en) begin
        dut_reads++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (err && err_rise < 0) err_rise = cyc;
    end
  end

  // One frame: start at cycle 0, grayscaler model and scenario events driven
  // 1 time unit after each rising edge.
  task automatic run_frame(input int kind, input bit pause_mode);
    gv_t vq[$];
    gv_t item;
    int  rd_seen    = 0;
    int  pause_left = 0;
    bit  finished   = 1'b0;
    frame_kind   = kind;
    end_cyc      = (kind == K_TIMEOUT) ? TO : 1000000;
    reads_mdl    = 0;
    wr_idx       = 0;
    dut_reads    = 0;
    done_cnt     = 0;
    first_rd_cyc = -1;
    done_cyc     = -1;
    err_rise     = -1;
    nxt_wr       = 1'b0;
    nxt_data     = 8'h00;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'h00;
    for (int c = 0; c < 200 && !finished; c++) begin
      @(posedge clk); #1;
      cyc       = c;
      pend_wr   = nxt_wr;
      pend_data = nxt_data;
      if (kind == K_RESET && c == 13) begin
        chk_on   = 1'b0;
        finished = 1'b1;
      end else begin
        start    = (c == 0);
        abort    = 1'b0;
        gs_valid = 1'b0;
        gs_done  = 1'b0;
        gs_pause = (pause_left > 0);
        if (pause_left > 0) pause_left--;
        if (vq.size() > 0 && vq[0].cyc == c) begin
          item     = vq.pop_front();
          gs_valid = 1'b1;
          gs_data  = item.data;
          gs_done  = item.last;
          if (kind == K_TIMEOUT) end_cyc = c + TO;
          else if (item.last)    end_cyc = c + 2;
        end
        if (kind == K_ABORT && c == 6) begin
          abort    = 1'b1;
          gs_valid = 1'b1;
          gs_data  = 8'hEE;
          end_cyc  = 7;
        end
        if (kind == K_EARLY && c == 9) begin
          gs_done = 1'b1;
          end_cyc = 10;
        end
        nxt_wr   = gs_valid && !abort;
        nxt_data = gs_data;
        if (c == 0) chk_on = 1'b1;
        #2;
        if (src_rd_en) begin
          rd_seen++;
          if (rd_seen % 3 == 0) begin
            if (pause_mode) pause_left = 2;
            if (kind == K_NORMAL || kind == K_RESET
                || (kind == K_TIMEOUT && rd_seen == 3)
                || (kind == K_EARLY && rd_seen <= 6))
              vq.push_back('{c + 2, 8'h10 + 8'(rd_seen / 3 - 1), rd_seen == 3 * NPIX});
          end
        end
        if (c >= end_cyc + 2) begin
          @(negedge clk); #1;
          chk_on   = 1'b0;
          finished = 1'b1;
        end
      end
    end
    if (!finished) begin
      chk_on = 1'b0;
      check("frame_bound", 32'd0, 32'd1);
    end
    start    = 1'b0;
    abort    = 1'b0;
    gs_valid = 1'b0;
    gs_done  = 1'b0;
    gs_pause = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    for (int k = 0; k < NPIX; k++) check({tag, "_mem"}, mem[k], 8'h10 + 8'(k));
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    gs_pause = 1'b0;
    gs_valid = 1'b0;
    gs_data  = 8'h00;
    gs_done  = 1'b0;
    #3;
    check("rst_flags", {busy, done, err, src_rd_en, gs_enable, dst_wr_en}, 32'd0);
    check("rst_buses", {src_addr, dst_addr, dst_data}, 32'd0);
    #17 rst_n = 1'b1;

    // plain frame
    run_frame(K_NORMAL, 1'b0);
    check("t1_reads", dut_reads, 12);
    check("t1_first_rd", first_rd_cyc, 1);
    check("t1_done_cyc", done_cyc, 16);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_err", err, 1'b0);
    check_mem("t1");

    // 2-cycle pause after every third read
    run_frame(K_NORMAL, 1'b1);
    check("t2_reads", dut_reads, 12);
    check("t2_done_cyc", done_cyc, 22);
    check_mem("t2");

    // only pixel 0 ever returns: watchdog fires 64 cycles after it
    run_frame(K_TIMEOUT, 1'b0);
    check("t3_err_rise", err_rise, 69);
    check("t3_done_cnt", done_cnt, 0);
    check("t3_err", err, 1'b1);
    check("t3_gs_enable", gs_enable, 1'b0);

    // abort while idle leaves err set
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("idle_abort_err", err, 1'b1);
    check("idle_abort_busy", busy, 1'b0);

    // abort after 5 reads, then a clean frame
    run_frame(K_ABORT, 1'b0);
    check("t4_reads", dut_reads, 5);
    check("t4_done_cnt", done_cnt, 0);
    run_frame(K_NORMAL, 1'b0);
    check("t4b_first_rd", first_rd_cyc, 1);
    check("t4b_done_cyc", done_cyc, 16);
    check_mem("t4b");

    // gs_done right after the second result
    run_frame(K_EARLY, 1'b0);
    check("t5_err_rise", err_rise, 10);
    check("t5_err", err, 1'b1);
    run_frame(K_NORMAL, 1'b0);
    check("t5b_err", err, 1'b0);
    check("t5b_done_cyc", done_cyc, 16);

    // async reset in DRAIN, start held during reset
    run_frame(K_RESET, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_flags", {busy, done, err, src_rd_en, gs_enable, dst_wr_en}, 32'd0);
    check("t6_rst_buses", {src_addr, dst_addr, dst_data}, 32'd0);
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t6_in_rst_busy", busy, 1'b0);
    start = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t6_post_rst_idle", {busy, src_rd_en}, 32'd0);
    end
    run_frame(K_NORMAL, 1'b0);
    check("t6b_done_cyc", done_cyc, 16);
    check_mem("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
